iwdg_seq_ctrl: RTL

//  Wishbone master that configures and services the IWDG slave. On start it runs:

---
 rtl/iwdg_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/iwdg_seq_ctrl.sv
// iwdg_seq_ctrl: Wishbone master that unlocks, configures and periodically refreshes an IWDG slave.
// Optional ack-timeout/error handling is compiled in when IWDG_SEQ_TIMEOUT_EN is defined.
//
// state    | meaning
// IDLE     | bus idle, waiting for start
// W_START  | writing KR = 0xCCCC (start watchdog)
// W_UNLOCK | writing KR = 0x5555 (unlock PR/RLR)
// W_RLR    | writing RLR = cfg_rlr
// W_PR     | writing PR = cfg_pr
// W_RELOAD | writing KR = 0xAAAA (initial reload)
// GAP      | one idle bus cycle between config writes
// RUN      | configured, timing the next refresh
// W_KICK   | writing KR = 0xAAAA (refresh)
// ERR      | ack timeout seen; bus idle until start
module iwdg_seq_ctrl #(
  parameter int          IWDG_KR_SIZE  = 16,
  parameter int          IWDG_PR_SIZE  = 3,
  parameter int          IWDG_RLR_SIZE = 12,
  parameter int          KICK_W        = 16,
  parameter int          TIMEOUT       = 64,
  parameter logic [31:0] BASE_ADR      = 32'h0100_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [IWDG_PR_SIZE-1:0]  cfg_pr,
  input  logic [IWDG_RLR_SIZE-1:0] cfg_rlr,
  input  logic [KICK_W-1:0]        kick_period,
  input  logic                     kick_req,
  output logic [31:0]              adr_m2s,
  output logic [IWDG_KR_SIZE-1:0]  dat_m2s,
  output logic                     we_m2s,
  output logic                     cyc_m2s,
  output logic                     stb_m2s,
  input  logic [IWDG_KR_SIZE-1:0]  dat_s2m,
  input  logic                     ack_s2m,
  output logic                     busy,
  output logic                     running,
  output logic [KICK_W-1:0]        kick_cnt,
  output logic                     err
);

  typedef enum logic [3:0] {
    IDLE, W_START, W_UNLOCK, W_RLR, W_PR, W_RELOAD, GAP, RUN, W_KICK, ERR
  } state_t;

  localparam logic [15:0] KEY_START  = 16'hCCCC;
  localparam logic [15:0] KEY_UNLOCK = 16'h5555;
  localparam logic [15:0] KEY_RELOAD = 16'hAAAA;
  localparam logic [31:0] ADR_KR     = BASE_ADR + 32'h0;
  localparam logic [31:0] ADR_PR     = BASE_ADR + 32'h4;
  localparam logic [31:0] ADR_RLR    = BASE_ADR + 32'h8;

  state_t                    state_q, state_d;
  state_t                    gap_nxt_q, gap_nxt_d;
  logic [IWDG_PR_SIZE-1:0]   cfg_pr_q, cfg_pr_d;
  logic [IWDG_RLR_SIZE-1:0]  cfg_rlr_q, cfg_rlr_d;
  logic [KICK_W-1:0]         per_cnt_q, per_cnt_d;
  logic [KICK_W-1:0]         kick_cnt_q, kick_cnt_d;
  logic [31:0]               adr_q, adr_d;
  logic [IWDG_KR_SIZE-1:0]   dat_q, dat_d;
  logic                      cyc_q, cyc_d;
  logic                      busy_q, busy_d;
  logic                      running_q, running_d;
  logic                      err_q, err_d;
  logic                      expire;
  logic                      timeout;

  logic unused_dat;
  assign unused_dat = ^dat_s2m;

`ifdef IWDG_SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;

  // Counts cycles of an open cycle without ack; restarts whenever the bus goes idle.
  always_comb begin
    wait_d  = '0;
    timeout = 1'b0;
    if (cyc_q && !ack_s2m) begin
      if (wait_q == WAIT_W'(TIMEOUT - 1)) timeout = 1'b1;
      else                                wait_d  = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wait_q <= '0;
    else      wait_q <= wait_d;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    gap_nxt_d  = gap_nxt_q;
    cfg_pr_d   = cfg_pr_q;
    cfg_rlr_d  = cfg_rlr_q;
    per_cnt_d  = per_cnt_q;
    kick_cnt_d = kick_cnt_q;
    err_d      = err_q;
    // >= rather than == so a period shortened below the current count fires at once
    expire     = (kick_period != '0) && (per_cnt_q >= kick_period - KICK_W'(1));

    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          state_d    = W_START;
          cfg_pr_d   = cfg_pr;
          cfg_rlr_d  = cfg_rlr;
          err_d      = 1'b0;
          kick_cnt_d = '0;
        end
      end
      W_START: begin
        if (ack_s2m) begin
          state_d   = GAP;
          gap_nxt_d = W_UNLOCK;
        end
      end
      W_UNLOCK: begin
        if (ack_s2m) begin
          state_d   = GAP;
          gap_nxt_d = W_RLR;
        end
      end
      W_RLR: begin
        if (ack_s2m) begin
          state_d   = GAP;
          gap_nxt_d = W_PR;
        end
      end
      W_PR: begin
        if (ack_s2m) begin
          state_d   = GAP;
          gap_nxt_d = W_RELOAD;
        end
      end
      W_RELOAD: begin
        if (ack_s2m) begin
          state_d   = RUN;
          per_cnt_d = '0;
        end
      end
      GAP: state_d = gap_nxt_q;
      RUN: begin
        // Expiry and request in the same cycle collapse into this single refresh;
        // requests arriving during W_KICK fold into it as well.
        if (expire || kick_req) begin
          state_d   = W_KICK;
          per_cnt_d = '0;
        end else begin
          per_cnt_d = per_cnt_q + KICK_W'(1);
        end
      end
      W_KICK: begin
        if (ack_s2m) begin
          state_d    = RUN;
          per_cnt_d  = '0;
          kick_cnt_d = kick_cnt_q + KICK_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d = ERR;
      err_d   = 1'b1;
    end

    // Bus outputs are decoded from the next state so they change on the entering edge.
    cyc_d = 1'b0;
    adr_d = adr_q;
    dat_d = dat_q;
    case (state_d)
      W_START: begin
        cyc_d = 1'b1;
        adr_d = ADR_KR;
        dat_d = IWDG_KR_SIZE'(KEY_START);
      end
      W_UNLOCK: begin
        cyc_d = 1'b1;
        adr_d = ADR_KR;
        dat_d = IWDG_KR_SIZE'(KEY_UNLOCK);
      end
      W_RLR: begin
        cyc_d = 1'b1;
        adr_d = ADR_RLR;
        dat_d = IWDG_KR_SIZE'(cfg_rlr_q);
      end
      W_PR: begin
        cyc_d = 1'b1;
        adr_d = ADR_PR;
        dat_d = IWDG_KR_SIZE'(cfg_pr_q);
      end
      W_RELOAD, W_KICK: begin
        cyc_d = 1'b1;
        adr_d = ADR_KR;
        dat_d = IWDG_KR_SIZE'(KEY_RELOAD);
      end
      default: ;
    endcase
    busy_d    = !(state_d inside {IDLE, RUN, ERR});
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gap_nxt_q  <= IDLE;
      cfg_pr_q   <= '0;
      cfg_rlr_q  <= '0;
      per_cnt_q  <= '0;
      kick_cnt_q <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      cyc_q      <= 1'b0;
      busy_q     <= 1'b0;
      running_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_nxt_q  <= gap_nxt_d;
      cfg_pr_q   <= cfg_pr_d;
      cfg_rlr_q  <= cfg_rlr_d;
      per_cnt_q  <= per_cnt_d;
      kick_cnt_q <= kick_cnt_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      cyc_q      <= cyc_d;
      busy_q     <= busy_d;
      running_q  <= running_d;
      err_q      <= err_d;
    end
  end

  assign adr_m2s  = adr_q;
  assign dat_m2s  = dat_q;
  assign cyc_m2s  = cyc_q;
  assign stb_m2s  = cyc_q;
  assign we_m2s   = cyc_q;
  assign busy     = busy_q;
  assign running  = running_q;
  assign kick_cnt = kick_cnt_q;
  assign err      = err_q;

endmodule
